// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the fetch path: datapath width, default boot
// address, the fetch packet layout, and a word-alignment helper.
// Contents: XLEN, DEFAULT_RESET_PC, fetch_packet_t, word_align().
`timescale 1ns/1ps
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Clears the two byte-offset bits of a fetch address.
  localparam logic [XLEN-1:0] WORD_MASK = ~32'h0000_0003;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_packet_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: small circular packet buffer with synchronous flush and an occupancy count.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: none internally; the producer must never push when full.
// Ports: clk/reset (sync, active-high); flush_i empties the buffer and wins over
// push_i/pop_i; push_dat_i is written at the tail; head_dat_o is the oldest
// entry; count_o is the number of valid entries (0..DEPTH).
`timescale 1ns/1ps
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter type T     = fetch_packet_t,
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  T              push_dat_i,
  input  logic          pop_i,
  output T              head_dat_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so pointer wrap is plain binary overflow.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + 1'b1;
      if (pop_i)  head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage carries no reset; entries are only observed once counted valid.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !reset) mem_q[tail_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[head_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch front end; issues PC requests to imem and buffers returned packets.
// Latency: 2 cycles from request acceptance to valid_out; one packet per cycle sustained.
// Backpressure: credit-based; a request is offered only if the buffer has room for its response.
// Ports: clk/reset (sync, active-high); mispredict/mispredict_pc flush and redirect;
// imem_req_valid/ready/addr request channel; imem_resp_valid/data response
// (fixed 1-cycle latency); valid_out/ready_out/data_out packet stream downstream.
`timescale 1ns/1ps
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mispredict,
  input  logic [XLEN-1:0] mispredict_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            valid_out,
  input  logic            ready_out,
  output fetch_packet_t   data_out
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tag_pc_q, tag_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]   count;
  logic [CW:0]     committed;
  logic            credit_ok;
  logic            accept;
  logic            push;
  logic            pop;
  logic            flush;
  fetch_packet_t   push_dat;

  assign valid_out = !reset && (count != '0);
  assign pop       = valid_out && ready_out;

  // Slots already spoken for: buffered packets plus the one in flight, minus
  // the one leaving this cycle. Issuing only below depth means a response
  // always finds a free slot, so the buffer can never overflow.
  assign committed = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign credit_ok = committed < (CW+1)'(BUF_DEPTH);

  assign imem_req_valid = !reset && !mispredict && credit_ok;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  // A response only counts if its request is still tracked; this drops
  // responses that were cancelled by a flush or by reset.
  assign push     = imem_resp_valid && inflight_q && !mispredict;
  assign push_dat = '{pc: tag_pc_q, instr: imem_resp_data};
  assign flush    = mispredict;

  always_comb begin
    pc_d       = pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = inflight_q;
    if (mispredict) begin
      pc_d       = word_align(mispredict_pc);
      inflight_d = 1'b0;
    end else begin
      if (accept) begin
        pc_d     = pc_q + 32'd4;
        tag_pc_d = pc_q;
      end
      // A new acceptance in the same cycle as a response keeps inflight set.
      inflight_d = accept | (inflight_q & ~imem_resp_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .T     (fetch_packet_t),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (data_out),
    .count_o    (count)
  );

endmodule
